// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, sequencer states and
// request legality rules.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W = 32;
  localparam int unsigned LSU_ADDR_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_HI = 3'd1,
    RD_LO = 3'd2,
    WR_HI = 3'd3,
    WR_LO = 3'd4,
    DONE  = 3'd5
  } state_e;

  // A request is rejected when it is ambiguous, reserved, or misaligned.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [1:0] sz, input logic [1:0] off);
    return (rd && wr) ||
           (sz == SIZE_RSVD) ||
           ((sz == SIZE_HALF) && off[0]) ||
           ((sz == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane extraction/extension for loads and lane merge for stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] word,
  input  logic [1:0]            offset,
  input  size_e                 size,
  input  logic                  is_signed,
  input  logic [LSU_DATA_W-1:0] store_data,
  output logic [LSU_DATA_W-1:0] load_value_c,
  output logic [LSU_DATA_W-1:0] merged_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_value_c = word;
    case (size)
      SIZE_BYTE: load_value_c = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_value_c = {{16{is_signed & half_sel[15]}}, half_sel};
      default:   load_value_c = word;
    endcase
  end

  always_comb begin
    merged_c = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0:    merged_c[31:24] = store_data[7:0];
          2'd1:    merged_c[23:16] = store_data[7:0];
          2'd2:    merged_c[15:8]  = store_data[7:0];
          default: merged_c[7:0]   = store_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged_c[15:0]  = store_data[15:0];
        else           merged_c[31:16] = store_data[15:0];
      end
      SIZE_WORD: merged_c = store_data;
      default:   merged_c = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage sequencer for the edge-strobed data memory: handles loads, word
// stores and read-modify-write sub-word stores, rejecting illegal requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORD_ADDR_W = 7,
  parameter int unsigned DATA_W      = LSU_DATA_W
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   memRead,
  input  logic                   memWrite,
  input  logic [1:0]             size,
  input  logic                   loadSigned,
  input  logic [LSU_ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]      storeData,
  output logic [DATA_W-1:0]      loadData,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  output logic [WORD_ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0]      memWriteData,
  output logic                   trigWrite,
  output logic                   trigRead,
  input  logic [DATA_W-1:0]      readData
);

  state_e            state;
  logic              req_write;
  size_e             req_size;
  logic [1:0]        req_offset;
  logic              req_signed;
  logic [DATA_W-1:0] req_store;
  logic [DATA_W-1:0] lane_load_c;
  logic [DATA_W-1:0] lane_merged_c;

  // Address bits above the memory depth wrap and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[LSU_ADDR_W-1:WORD_ADDR_W+2]};

  lsu_byte_lane u_lane (
    .word        (readData),
    .offset      (req_offset),
    .size        (req_size),
    .is_signed   (req_signed),
    .store_data  (req_store),
    .load_value_c(lane_load_c),
    .merged_c    (lane_merged_c)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      trigRead     <= 1'b0;
      trigWrite    <= 1'b0;
      loadData     <= '0;
      memWriteData <= '0;
      memAddress   <= '0;
      req_write    <= 1'b0;
      req_size     <= SIZE_BYTE;
      req_offset   <= 2'b00;
      req_signed   <= 1'b0;
      req_store    <= '0;
    end else begin
      // Strobes and completion flags are single-cycle pulses by default.
      trigRead  <= 1'b0;
      trigWrite <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b1;
      case (state)
        IDLE: begin
          if (memRead || memWrite) begin
            memAddress <= addr[WORD_ADDR_W+1:2];
            req_write  <= memWrite;
            req_size   <= size_e'(size);
            req_offset <= addr[1:0];
            req_signed <= loadSigned;
            req_store  <= storeData;
            if (req_illegal(memRead, memWrite, size, addr[1:0])) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (memWrite && (size_e'(size) == SIZE_WORD)) begin
              state        <= WR_HI;
              trigWrite    <= 1'b1;
              memWriteData <= storeData;
            end else begin
              state    <= RD_HI;
              trigRead <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RD_HI: state <= RD_LO;
        RD_LO: begin
          if (req_write) begin
            state        <= WR_HI;
            trigWrite    <= 1'b1;
            memWriteData <= lane_merged_c;
          end else begin
            state    <= DONE;
            done     <= 1'b1;
            loadData <= lane_load_c;
          end
        end
        WR_HI: state <= WR_LO;
        WR_LO: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a strobe-driven memory model
// and an arithmetic reference model of load extension and store merging.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0, loadSigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, storeData = '0;
  logic [31:0] loadData, memWriteData;
  logic [31:0] readData = '0;
  logic        done, err, busy, trigWrite, trigRead;
  logic [6:0]  memAddress;

  logic [31:0] phys [128];
  logic [31:0] ref_mem [128];
  bit          init_done;

  int n_checks = 0, n_pass = 0;
  int o_done_cyc, o_rd_cnt, o_wr_cnt, o_rd_cyc, o_wr_cyc;
  logic [31:0] o_ld, o_wr_data;
  logic [6:0]  o_wr_addr;
  logic        o_err, o_viol, o_after;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .resetN(resetN), .memRead(memRead), .memWrite(memWrite),
    .size(size), .loadSigned(loadSigned), .addr(addr), .storeData(storeData),
    .loadData(loadData), .done(done), .err(err), .busy(busy),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .trigWrite(trigWrite), .trigRead(trigRead), .readData(readData)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'(i) * 32'h9E3779B9 + 32'h0000_1234;
  endfunction

  // Memory acts mid-cycle while a strobe is high, i.e. after its rising edge.
  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) phys[i] <= init_val(i);
      init_done <= 1'b1;
    end else begin
      if (trigWrite) phys[memAddress] <= memWriteData;
      if (trigRead)  readData <= phys[memAddress];
    end
  end

  function automatic logic model_illegal(input logic rd, input logic wr, input int sz,
                                         input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (sz == 3) return 1'b1;
    if (sz == 1 && (a % 2) != 0) return 1'b1;
    if (sz == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int sz,
                                             input logic [31:0] a, input logic sgn);
    int sh;
    logic [31:0] v;
    if (sz == 0) begin
      sh = 8 * (3 - int'(a % 4));
      v = (w >> sh) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      sh = 8 * (2 - int'(a % 4));
      v = (w >> sh) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input int sz,
                                              input logic [31:0] a, input logic [31:0] d);
    int sh;
    logic [31:0] mask;
    if (sz == 2) return d;
    sh = (sz == 0) ? 8 * (3 - int'(a % 4)) : 8 * (2 - int'(a % 4));
    mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Issue one request, hold it until done, and record what the unit did.
  task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] a, input logic [31:0] d);
    logic prev;
    @(negedge clk);
    memRead = rd; memWrite = wr; size = sz; loadSigned = sgn; addr = a; storeData = d;
    o_done_cyc = -1; o_rd_cnt = 0; o_wr_cnt = 0; o_rd_cyc = -1; o_wr_cyc = -1;
    o_err = 1'bx; o_ld = 'x; o_viol = 1'b0; o_wr_addr = 'x; o_wr_data = 'x;
    prev = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (trigRead && trigWrite) o_viol = 1'b1;
      if ((trigRead || trigWrite) && prev) o_viol = 1'b1;
      prev = trigRead | trigWrite;
      if (trigRead) begin o_rd_cnt++; o_rd_cyc = c; end
      if (trigWrite) begin
        o_wr_cnt++; o_wr_cyc = c; o_wr_addr = memAddress; o_wr_data = memWriteData;
      end
      if (done) begin o_done_cyc = c; o_err = err; o_ld = loadData; break; end
    end
    memRead = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    o_after = done | err | busy | trigRead | trigWrite;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if ({done, err, busy, trigRead, trigWrite} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {done, err, busy, trigRead, trigWrite}); else n_pass++;
    n_checks++; if ({loadData, memWriteData, memAddress} !== 71'b0)
      $display("FAIL reset_data got=%h/%h/%h exp=0", loadData, memWriteData, memAddress); else n_pass++;
    resetN = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_word_store_load();
    run_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    ref_mem[4] = 32'hDEADBEEF;
    n_checks++; if (o_wr_cnt !== 1 || o_wr_cyc !== 1)
      $display("FAIL wst_strobe got=cnt%0d cyc%0d exp=cnt1 cyc1", o_wr_cnt, o_wr_cyc); else n_pass++;
    n_checks++; if (o_wr_addr !== 7'd4 || o_wr_data !== 32'hDEADBEEF)
      $display("FAIL wst_bus got=%h/%h exp=04/deadbeef", o_wr_addr, o_wr_data); else n_pass++;
    n_checks++; if (o_done_cyc !== 3 || o_rd_cnt !== 0 || o_err !== 1'b0)
      $display("FAIL wst_done got=cyc%0d rd%0d err%b exp=cyc3 rd0 err0", o_done_cyc, o_rd_cnt, o_err); else n_pass++;
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_checks++; if (o_rd_cnt !== 1 || o_rd_cyc !== 1 || o_wr_cnt !== 0)
      $display("FAIL wld_strobe got=rd%0d cyc%0d wr%0d exp=rd1 cyc1 wr0", o_rd_cnt, o_rd_cyc, o_wr_cnt); else n_pass++;
    n_checks++; if (o_done_cyc !== 3 || o_ld !== 32'hDEADBEEF || o_err !== 1'b0)
      $display("FAIL wld_data got=cyc%0d %h err%b exp=cyc3 deadbeef err0", o_done_cyc, o_ld, o_err); else n_pass++;
    n_checks++; if (o_after !== 1'b0) $display("FAIL wld_one_cycle got=%b exp=0", o_after); else n_pass++;
  endtask

  task automatic test_subword_loads();
    run_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    n_checks++; if (o_ld !== 32'hFFFFFFAD || o_done_cyc !== 3)
      $display("FAIL lb_signed got=%h cyc%0d exp=ffffffad cyc3", o_ld, o_done_cyc); else n_pass++;
    run_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    n_checks++; if (o_ld !== 32'h000000AD) $display("FAIL lb_unsigned got=%h exp=000000ad", o_ld); else n_pass++;
    run_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    n_checks++; if (o_ld !== 32'hFFFFBEEF) $display("FAIL lh_signed got=%h exp=ffffbeef", o_ld); else n_pass++;
  endtask

  task automatic test_byte_store();
    run_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0055);
    ref_mem[4] = 32'hDEADBE55;
    n_checks++; if (o_rd_cyc !== 1 || o_wr_cyc !== 3 || o_rd_cnt !== 1 || o_wr_cnt !== 1)
      $display("FAIL sb_strobes got=rd@%0d wr@%0d exp=rd@1 wr@3", o_rd_cyc, o_wr_cyc); else n_pass++;
    n_checks++; if (o_wr_data !== 32'hDEADBE55 || o_done_cyc !== 5)
      $display("FAIL sb_merge got=%h cyc%0d exp=deadbe55 cyc5", o_wr_data, o_done_cyc); else n_pass++;
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_checks++; if (o_ld !== 32'hDEADBE55) $display("FAIL sb_readback got=%h exp=deadbe55", o_ld); else n_pass++;
  endtask

  task automatic test_errors();
    logic        rds [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  szs [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ads [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
    for (int k = 0; k < 4; k++) begin
      run_req(rds[k], wrs[k], szs[k], 1'b0, ads[k], 32'h12345678);
      n_checks++; if (o_done_cyc !== 1 || o_err !== 1'b1 || o_rd_cnt !== 0 || o_wr_cnt !== 0)
        $display("FAIL err_case%0d got=cyc%0d err%b rd%0d wr%0d exp=cyc1 err1 rd0 wr0",
                 k, o_done_cyc, o_err, o_rd_cnt, o_wr_cnt); else n_pass++;
    end
    n_checks++; if (phys[4] !== ref_mem[4]) $display("FAIL err_mem got=%h exp=%h", phys[4], ref_mem[4]); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    memWrite = 1'b1; size = 2'b00; addr = 32'h13; storeData = 32'hAA;
    @(posedge clk); #2;
    n_checks++; if (trigRead !== 1'b1) $display("FAIL rst_rdhi got=%b exp=1", trigRead); else n_pass++;
    resetN = 1'b0; #1;
    n_checks++; if ({trigRead, trigWrite, busy} !== 3'b0)
      $display("FAIL rst_async got=%b exp=000", {trigRead, trigWrite, busy}); else n_pass++;
    @(negedge clk); memWrite = 1'b0;
    @(negedge clk); resetN = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || loadData !== 32'h0)
      $display("FAIL rst_release got=busy%b ld%h exp=busy0 ld0", busy, loadData); else n_pass++;
    n_checks++; if (phys[4] !== ref_mem[4]) $display("FAIL rst_mem got=%h exp=%h", phys[4], ref_mem[4]); else n_pass++;
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    n_checks++; if (o_done_cyc !== 3 || o_ld !== ref_mem[4])
      $display("FAIL rst_next got=cyc%0d %h exp=cyc3 %h", o_done_cyc, o_ld, ref_mem[4]); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_ld, a, d;
    logic        rd, wr, sgn, ill;
    int          k, sz, exp_done, exp_rd, exp_wr;
    exp_ld = o_ld;
    for (int it = 0; it < 60; it++) begin
      k   = int'($urandom_range(0, 9));
      rd  = (k < 5) || (k == 9);
      wr  = (k >= 5);
      sz  = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      d   = $urandom;
      run_req(rd, wr, 2'(sz), sgn, a, d);
      ill = model_illegal(rd, wr, sz, a);
      exp_done = ill ? 1 : ((rd || sz == 2) ? 3 : 5);
      exp_rd   = (ill || (wr && sz == 2)) ? 0 : 1;
      exp_wr   = (!ill && wr) ? 1 : 0;
      if (!ill && rd) exp_ld = model_load(ref_mem[(a / 4) % 128], sz, a, sgn);
      if (!ill && wr) ref_mem[(a / 4) % 128] = model_store(ref_mem[(a / 4) % 128], sz, a, d);
      n_checks++; if (o_done_cyc !== exp_done || o_err !== ill)
        $display("FAIL rnd%0d_done got=cyc%0d err%b exp=cyc%0d err%b", it, o_done_cyc, o_err, exp_done, ill); else n_pass++;
      n_checks++; if (o_rd_cnt !== exp_rd || o_wr_cnt !== exp_wr || o_viol !== 1'b0)
        $display("FAIL rnd%0d_strobes got=rd%0d wr%0d viol%b exp=rd%0d wr%0d viol0",
                 it, o_rd_cnt, o_wr_cnt, o_viol, exp_rd, exp_wr); else n_pass++;
      n_checks++; if (o_ld !== exp_ld)
        $display("FAIL rnd%0d_load got=%h exp=%h", it, o_ld, exp_ld); else n_pass++;
    end
    for (int i = 0; i < 128; i++) begin
      n_checks++; if (phys[i] !== ref_mem[i])
        $display("FAIL mem_word%0d got=%h exp=%h", i, phys[i], ref_mem[i]); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_byte_store();
    test_errors();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequencer between the MEM pipeline stage and the 128-word data memory.
- Accepts byte, halfword and word load/store requests with byte addresses.
- Generates the edge-triggered trigRead/trigWrite pulses the memory requires.
- Performs read-modify-write for sub-word stores and sign/zero-extends loads; flags misaligned or illegal requests without touching memory.

Parameters:
WORD_ADDR_W, 7, width of memory word index (memory depth = 2**WORD_ADDR_W words)
DATA_W, 32, data word width

Ports:
clk  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
memRead  input  1  load request, sampled in IDLE
memWrite  input  1  store request, sampled in IDLE
size  input  2  00 byte, 01 half, 10 word, 11 reserved
loadSigned  input  1  1 = sign-extend sub-word load
addr  input  32  byte address
storeData  input  32  store data, right-justified for sub-word
loadData  output  32  extended load result, valid while done=1
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = request rejected
busy  output  1  state != IDLE
memAddress  output  WORD_ADDR_W  word index to memory
memWriteData  output  32  word to memory
trigWrite  output  1  memory write strobe (rising edge writes)
trigRead  output  1  memory read strobe (rising edge reads)
readData  input  32  memory read port

Behaviour:
- All outputs are registered. Reset (async, resetN=0) forces: state IDLE; trigRead, trigWrite, done, err = 0; loadData, memWriteData = 0; memAddress = 0. busy is 0 in IDLE.
- Byte lanes are big-endian: offset 0 = bits 31:24, offset 3 = bits 7:0. memAddress = addr[WORD_ADDR_W+1:2]. Upper address bits are ignored (wrap).
- Error conditions are checked in IDLE:
  - memRead and memWrite both high;
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
  - On error: go to DONE with err=1. No strobe is ever raised.
- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE.
- Request accepted at edge E0 (IDLE, memRead|memWrite). memAddress is latched at E0 and held until return to IDLE.
- Load: E0 -> RD_HI (trigRead=1); E1 -> RD_LO (trigRead=0); E2 captures readData, extracts the lane, extends it -> DONE (done=1, loadData valid); E3 -> IDLE.
- Word store: E0 -> WR_HI (trigWrite=1, memWriteData=storeData); E1 -> WR_LO (trigWrite=0); E2 -> DONE; E3 -> IDLE.
- Sub-word store: E0 -> RD_HI; E1 -> RD_LO; E2 captures readData, merges storeData[7:0] or [15:0] into the addressed lane(s), loads memWriteData -> WR_HI; E3 -> WR_LO; E4 -> DONE; E5 -> IDLE.
- memWriteData is stable for the whole cycle before and after the trigWrite rising edge. trigRead and trigWrite are never high in the same cycle and never high in consecutive cycles.
- Requests while busy=1 are ignored. The pipeline must hold requests until done.
- done and err stay high exactly one cycle. loadData holds its value until the next load completes.
- Reset mid-operation: strobes drop immediately. A write whose trigWrite edge already occurred is committed; otherwise memory is unchanged.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state enum;
  - DATA_W default.
- One combinational sub-module lsu_byte_lane: given word, offset, size, signed and store data, produces the extended load value and the merged store word.

Test Plan:
- Store word, addr 0x10, data 0xDEADBEEF -> one trigWrite pulse in cycle 1 with memAddress=4 and memWriteData=0xDEADBEEF; done in cycle 3; no trigRead.
- Load word, addr 0x10 -> one trigRead pulse in cycle 1; done in cycle 3 with loadData=0xDEADBEEF, err=0.
- Byte loads at addr 0x11: loadSigned=1 gives loadData=0xFFFFFFAD; loadSigned=0 gives 0x000000AD. Signed half load at 0x12 gives 0xFFFFBEEF.
- Store byte 0x55 at addr 0x13 -> trigRead in cycle 1, trigWrite in cycle 3 with 0xDEADBE55, done in cycle 5. A subsequent word load returns 0xDEADBE55.
- Misaligned word load at 0x12, half store at 0x11, size=11, and memRead+memWrite together -> each gives done=err=1 in cycle 1 with zero strobes; memory is unchanged.
- resetN pulsed low during RD_HI of a sub-word store -> strobes 0 immediately, busy=0 after release; word 4 is unchanged and the next request is accepted normally.
